lsu_initiator: RTL and testbench
================================

LSU_INITIATOR -- requirements
Module: lsu_initiator

Interface
REQ-001 The parameter list SHALL be: TIMEOUT, default 15, the number of WAIT cycles without valid before the access is aborted (range 1..255).
REQ-002 The port list SHALL be, clock and reset first:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
REQ-003 The core-side ports SHALL be:
- ls_start  in  1  single-cycle access strobe.
- ls_is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I load/store width code.
- addr  in  32  byte address.
- store_data  in  32  store source register.
REQ-004 The core-side result ports SHALL be:
- ls_busy  out  1  access in flight.
- ls_done  out  1  one-cycle completion pulse.
- load_data  out  32  formatted load result.
- err  out  2  completion status: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-005 The memory-side ports SHALL be:
- request  out  1  access request.
- address  out  8  word address, equal to addr[9:2].
- w_data  out  32  write data.
- masking  out  4  byte enables.
- we_re  out  1  1 = write, 0 = read.
- valid  in  1  responder acknowledge, asserted the cycle after request is sampled.
- r_data  in  32  read word, sampled only while valid=1.

Function
REQ-006 The FSM SHALL have the states IDLE, REQ, WAIT and FAULT; all outputs SHALL be registered.
REQ-007 In IDLE with ls_start=1, a legal and aligned access SHALL latch addr, funct3, ls_is_store and store_data, then go to REQ.
REQ-008 In REQ, request SHALL be 1 for exactly one cycle, after which the FSM goes to WAIT; request SHALL be 0 in every other state.
REQ-009 address, masking, w_data and we_re SHALL hold stable from REQ entry until the cycle ls_done is asserted.
REQ-010 In WAIT with valid=1, the block SHALL capture the formatted r_data into load_data, pulse ls_done with err=00, and return to IDLE.
REQ-011 Nominal latency SHALL be: ls_start sampled at edge N, request high in cycle N+1, ls_done high in cycle N+3.
REQ-012 A WAIT cycle counter SHALL clear on REQ entry; when it reaches TIMEOUT with valid=0, the block SHALL pulse ls_done with err=10, leave load_data unchanged, and return to IDLE.
REQ-013 Alignment SHALL be checked as follows: halfword with addr[0]=1, or word with addr[1:0]!=0, SHALL go to FAULT with no request issued.
REQ-014 Illegal funct3 SHALL be: for loads 3, 6, 7; for stores 3 through 7; it SHALL go to FAULT with no request issued; illegal funct3 takes priority over misalignment.
REQ-015 FAULT SHALL last one cycle, pulse ls_done with err=01 or 11, leave load_data unchanged, and then go to IDLE (done at N+2).
REQ-016 Store encoding SHALL be:
- SB: masking=4'b0001<<addr[1:0], w_data={4{store_data[7:0]}}.
- SH: masking=4'b0011<<addr[1:0], w_data={2{store_data[15:0]}}.
- SW: masking=4'b1111, w_data=store_data.
- we_re=1.
REQ-017 Load encoding SHALL be: masking=4'b1111, we_re=0, w_data=0.
REQ-018 Load formatting SHALL select the lane by addr[1:0] as follows:
- LB and LH sign-extend.
- LBU and LHU zero-extend.
- LW passes r_data through.
REQ-019 ls_busy SHALL be 1 in REQ, WAIT and FAULT, and 0 in IDLE.
REQ-020 ls_start while ls_busy=1 SHALL be ignored.
REQ-021 ls_start in the cycle ls_done is asserted SHALL be accepted, because the FSM is already in IDLE in that cycle.
REQ-022 valid=1 outside WAIT SHALL be ignored.
REQ-023 valid and timeout in the same cycle SHALL complete with err=00.

Reset
REQ-024 rst=0 SHALL immediately force the following values: state IDLE, request=0, address=0, w_data=0, masking=0, we_re=0, ls_busy=0, ls_done=0, load_data=0, err=00, counter=0.
REQ-025 Reset during REQ or WAIT SHALL abandon the access with no ls_done; a valid arriving after reset release SHALL be ignored.

Verification
REQ-026 The bench SHALL cover an SW followed by an LW: SW addr=0x14, data=0xDEADBEEF -> address=5, masking=1111, we_re=1, done at N+3; then LW addr=0x14 -> load_data=0xDEADBEEF, err=00.
REQ-027 The bench SHALL cover LB and LBU: LB addr=0x17 with r_data=0x80FF1234 -> load_data=0xFFFFFF80; LBU from the same address -> 0x00000080.
REQ-028 The bench SHALL cover SH: SH addr=0x22, store_data=0x0000ABCD -> masking=1100, w_data=0xABCDABCD, address=8.
REQ-029 The bench SHALL cover faults: LW addr=0x13 -> no request, done at N+2, err=01; load funct3=3 -> err=11.
REQ-030 The bench SHALL cover timeout: valid tied to 0, TIMEOUT=15 -> ls_done with err=10 after 15 WAIT cycles, load_data unchanged.
REQ-031 The bench SHALL cover reset mid-operation: rst=0 during WAIT -> outputs return to their reset values at once, no ls_done; after release a new LW completes normally.

Source files
------------

// File: rtl/lsu_initiator.sv
// Load/store initiator: turns a single-cycle core access strobe into one memory-side
// request, formats the returned word and reports completion status.
module lsu_initiator #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ls_start,
   input  logic        ls_is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        ls_busy,
   output logic        ls_done,
   output logic [31:0] load_data,
   output logic [1:0]  err,
   output logic        request,
   output logic [7:0]  address,
   output logic [31:0] w_data,
   output logic [3:0]  masking,
   output logic        we_re,
   input  logic        valid,
   input  logic [31:0] r_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FAULT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [1:0]  fault_err;
   logic [1:0]  start_code;
   logic        unused_addr_hi;

   // Illegal width code outranks misalignment; 2'b00 means the access may proceed.
   function automatic logic [1:0] check_access(input logic is_store, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic illegal;
      logic misaligned;
      illegal    = is_store ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
      if (illegal)
         check_access = 2'b11;
      else if (misaligned)
         check_access = 2'b01;
      else
         check_access = 2'b00;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   store_mask = 4'b0001 << off;
         2'b01:   store_mask = 4'b0011 << off;
         default: store_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_word(input logic [2:0] f3, input logic [31:0] sd);
      case (f3[1:0])
         2'b00:   store_word = {4{sd[7:0]}};
         2'b01:   store_word = {2{sd[15:0]}};
         default: store_word = sd;
      endcase
   endfunction

   function automatic logic [31:0] format_load(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] off);
      logic [15:0]        lane;
      logic signed [7:0]  b_s;
      logic signed [15:0] h_s;
      lane = 16'(word >> {off, 3'b000});
      b_s  = lane[7:0];
      h_s  = lane;
      case (f3)
         3'd0:    format_load = 32'(b_s);
         3'd1:    format_load = 32'(h_s);
         3'd4:    format_load = {24'd0, lane[7:0]};
         3'd5:    format_load = {16'd0, lane};
         default: format_load = word;
      endcase
   endfunction

   assign start_code     = check_access(ls_is_store, funct3, addr[1:0]);
   assign unused_addr_hi = ^addr[31:10];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         fault_err <= 2'b00;
         request   <= 1'b0;
         address   <= 8'd0;
         w_data    <= 32'd0;
         masking   <= 4'd0;
         we_re     <= 1'b0;
         ls_busy   <= 1'b0;
         ls_done   <= 1'b0;
         load_data <= 32'd0;
         err       <= 2'b00;
      end else begin
         ls_done <= 1'b0;
         request <= 1'b0;
         case (state)
            IDLE: begin
               if (ls_start) begin
                  ls_busy <= 1'b1;
                  if (start_code != 2'b00) begin
                     fault_err <= start_code;
                     state     <= FAULT;
                  end else begin
                     f3_q     <= funct3;
                     off_q    <= addr[1:0];
                     wait_cnt <= 8'd0;
                     request  <= 1'b1;
                     address  <= addr[9:2];
                     we_re    <= ls_is_store;
                     masking  <= ls_is_store ? store_mask(funct3, addr[1:0]) : 4'b1111;
                     w_data   <= ls_is_store ? store_word(funct3, store_data) : 32'd0;
                     state    <= REQ;
                  end
               end
            end
            REQ: state <= WAIT;
            WAIT: begin
               // A response in the final allowed cycle still counts as a success.
               if (valid) begin
                  load_data <= format_load(r_data, f3_q, off_q);
                  err       <= 2'b00;
                  ls_done   <= 1'b1;
                  ls_busy   <= 1'b0;
                  state     <= IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  err     <= 2'b10;
                  ls_done <= 1'b1;
                  ls_busy <= 1'b0;
                  state   <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            FAULT: begin
               err     <= fault_err;
               ls_done <= 1'b1;
               ls_busy <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_initiator.sv
// Randomized bench for lsu_initiator: a word-array responder plus a rule-level model
// of access legality, latency, store encoding and load formatting.
module tb_lsu_initiator;
   localparam int TIMEOUT = 15;

   logic        clk, rst, ls_start, ls_is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        ls_busy, ls_done, request, we_re, valid;
   logic [31:0] load_data, w_data, r_data;
   logic [1:0]  err;
   logic [7:0]  address;
   logic [3:0]  masking;

   int n_chk = 0, n_pass = 0;
   logic [31:0] resp_mem  [256];
   logic [31:0] model_mem [256];
   logic [31:0] model_load = 32'd0;
   int   resp_delay = 0;
   logic spurious_en = 1'b0;

   lsu_initiator #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ls_start(ls_start), .ls_is_store(ls_is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .ls_busy(ls_busy),
      .ls_done(ls_done), .load_data(load_data), .err(err), .request(request),
      .address(address), .w_data(w_data), .masking(masking), .we_re(we_re),
      .valid(valid), .r_data(r_data));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   // Responder: answers a request resp_delay cycles after the earliest legal cycle.
   initial begin
      int         pend, pend_cnt;
      logic [7:0] pa;
      logic [3:0] pm;
      logic [31:0] pw;
      logic       pwe;
      pend = 0; pend_cnt = 0; pa = 0; pm = 0; pw = 0; pwe = 0;
      valid = 1'b0; r_data = 32'd0;
      forever begin
         @(negedge clk);
         valid = 1'b0;
         if (spurious_en && pend == 0) begin
            valid  = 1'($urandom_range(0, 1));
            r_data = $urandom;
         end
         if (pend != 0) begin
            if (pend_cnt == 0) begin
               valid  = 1'b1;
               r_data = resp_mem[pa];
               if (pwe)
                  for (int i = 0; i < 4; i++)
                     if (pm[i]) resp_mem[pa][8*i +: 8] = pw[8*i +: 8];
               pend = 0;
            end else pend_cnt--;
         end
         if (request) begin
            pend = 1; pend_cnt = resp_delay;
            pa = address; pm = masking; pw = w_data; pwe = we_re;
         end
      end
   end

   function automatic logic [31:0] fmt(input logic [31:0] w, input int f3, input int off);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * off)) & 32'hFFFF;
      case (f3)
         0: return (b >= 128) ? b - 256 : b;
         1: return (h >= 32768) ? h - 65536 : h;
         4: return b;
         5: return h;
         default: return w;
      endcase
   endfunction

   task automatic do_access(input logic st, input int f3, input logic [31:0] a,
                            input logic [31:0] sd, input int k, input logic poke);
      int size, off, widx, exp_err, exp_lat, lat, req_cnt, hold_bad;
      logic legal_f3;
      logic [31:0] exp_mask, exp_wd, bm, word;
      size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      off  = int'(a % 4);
      widx = int'((a / 4) % 256);
      legal_f3 = st ? (f3 <= 2) : (f3 inside {0, 1, 2, 4, 5});
      if (!legal_f3)                begin exp_err = 3; exp_lat = 2; end
      else if (a % size != 0)       begin exp_err = 1; exp_lat = 2; end
      else if (k <= TIMEOUT - 1)    begin exp_err = 0; exp_lat = 3 + k; end
      else                          begin exp_err = 2; exp_lat = 2 + TIMEOUT; end
      exp_mask = !st ? 32'hF : (size == 4) ? 32'hF : (((1 << size) - 1) << off);
      exp_wd   = !st ? 32'd0 : (size == 1) ? (sd & 32'hFF) * 32'h01010101 :
                 (size == 2) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      word = model_mem[widx];
      if (exp_err == 0) begin
         model_load = fmt(word, f3, off);
         if (st) begin
            bm = 32'd0;
            for (int i = 0; i < 4; i++) if (exp_mask[i]) bm = bm | (32'hFF << (8 * i));
            model_mem[widx] = (word & ~bm) | (exp_wd & bm);
         end
      end

      resp_delay = k;
      ls_start = 1'b1; ls_is_store = st; funct3 = 3'(f3); addr = a; store_data = sd;
      lat = -1; req_cnt = 0; hold_bad = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (cyc == 1 && poke) begin
            ls_is_store = 1'($urandom_range(0, 1)); funct3 = 3'd2;
            addr = $urandom & 32'hFFFF_FFFC; store_data = $urandom;
         end else ls_start = 1'b0;
         if (cyc == 1) chk("busy_start", 32'(ls_busy), 32'd1);
         if (request) req_cnt++;
         if (exp_err == 0 || exp_err == 2)
            if (address !== a[9:2] || 32'(masking) !== exp_mask || w_data !== exp_wd ||
                we_re !== st) hold_bad++;
         if (ls_done) begin lat = cyc; break; end
      end
      ls_start = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("err", 32'(err), 32'(exp_err));
      chk("load_data", load_data, model_load);
      chk("req_count", 32'(req_cnt), (exp_err == 0 || exp_err == 2) ? 32'd1 : 32'd0);
      chk("busy_done", 32'(ls_busy), 32'd0);
      if (exp_err == 0 || exp_err == 2) chk("mem_fields", 32'(hold_bad), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(ls_busy), 32'd0);
      chk({tag, "_done"}, 32'(ls_done), 32'd0);
      chk({tag, "_req"}, 32'(request), 32'd0);
      chk({tag, "_address"}, 32'(address), 32'd0);
      chk({tag, "_wdata"}, w_data, 32'd0);
      chk({tag, "_mask"}, 32'(masking), 32'd0);
      chk({tag, "_we"}, 32'(we_re), 32'd0);
      chk({tag, "_ld"}, load_data, 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic reset_mid_wait();
      int done_seen;
      resp_delay = 5;
      ls_start = 1'b1; ls_is_store = 1'b0; funct3 = 3'd2; addr = 32'h14; store_data = 0;
      @(negedge clk); ls_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      model_load = 32'd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (ls_done) done_seen++;
      end
      chk("rst_no_done", 32'(done_seen), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int k, f3;
      logic st;
      for (int i = 0; i < 256; i++) begin
         resp_mem[i]  = $urandom;
         model_mem[i] = resp_mem[i];
      end
      rst = 1'b0; ls_start = 1'b0; ls_is_store = 1'b0; funct3 = 3'd0;
      addr = 32'd0; store_data = 32'd0;
      repeat (2) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;
      @(negedge clk);

      do_access(1'b1, 2, 32'h14, 32'hDEADBEEF, 0, 1'b0);
      do_access(1'b0, 2, 32'h14, 32'd0, 0, 1'b0);
      chk("lw_deadbeef", load_data, 32'hDEADBEEF);
      do_access(1'b1, 2, 32'h14, 32'h80FF1234, 0, 1'b0);
      do_access(1'b0, 0, 32'h17, 32'd0, 0, 1'b0);
      chk("lb_sign", load_data, 32'hFFFFFF80);
      do_access(1'b0, 4, 32'h17, 32'd0, 0, 1'b0);
      chk("lbu_zero", load_data, 32'h00000080);
      do_access(1'b1, 1, 32'h22, 32'h0000ABCD, 0, 1'b0);
      do_access(1'b0, 2, 32'h20, 32'd0, 1, 1'b0);
      do_access(1'b0, 2, 32'h13, 32'd0, 0, 1'b0);
      do_access(1'b0, 3, 32'h10, 32'd0, 0, 1'b0);
      do_access(1'b1, 4, 32'h10, 32'd0, 0, 1'b0);
      do_access(1'b1, 5, 32'h01, 32'd0, 0, 1'b0);
      do_access(1'b0, 1, 32'h03, 32'd0, 0, 1'b0);
      do_access(1'b1, 1, 32'h21, 32'd0, 0, 1'b0);
      do_access(1'b0, 2, 32'h14, 32'd0, 255, 1'b0);
      do_access(1'b0, 2, 32'h18, 32'd0, 14, 1'b0);
      do_access(1'b0, 2, 32'h1C, 32'd0, 15, 1'b0);
      do_access(1'b0, 5, 32'h16, 32'd0, 2, 1'b1);
      reset_mid_wait();
      do_access(1'b0, 2, 32'h14, 32'd0, 0, 1'b0);
      chk("lw_after_rst", load_data, 32'h80FF1234);

      // Random traffic with stray valids between accesses.
      spurious_en = 1'b1;
      for (int n = 0; n < 80; n++) begin
         st = 1'($urandom_range(0, 1));
         f3 = $urandom_range(0, 7);
         a = $urandom;
         a[9:2] = 8'($urandom_range(0, 7));
         a[1:0] = 2'($urandom_range(0, 3));
         if (st) k = $urandom_range(0, 3);
         else begin
            k = $urandom_range(0, 9);
            k = (k < 7) ? k % 4 : (k == 7) ? 14 : (k == 8) ? 15 : 255;
         end
         do_access(st, f3, a, $urandom, k, ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      spurious_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
